// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// No logic; default geometry plus the per-cycle operation encoding.
// Backpressure is not applicable here.
package sync_fifo_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_AW    = $clog2(DEF_DEPTH);

    typedef logic [DEF_AW-1:0] ptr_t;
    typedef logic [DEF_AW:0]   cnt_t;

    // Which side actually completes this cycle, as {write, read}
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } op_t;

    function automatic op_t op_decode(input logic wr_ok, input logic rd_ok);
        return op_t'({wr_ok, rd_ok});
    endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer bus of the FIFO: requests, read data, strobes and level flags.
// No logic or latency; master drives requests, slave (the FIFO) drives status.
// Backpressure is reported through full/overflow and empty/underflow.
interface sync_fifo_if #(
    parameter int FIFO_WIDTH = 16
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  almostfull;
    logic                  empty;
    logic                  almostempty;

    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, almostfull, empty, almostempty
    );

    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, almostfull, empty, almostempty
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// 1-write/1-read register array with a registered read port.
// Read data appears one cycle after i_rd_en; writes land on the same edge.
// No backpressure: the caller guarantees enables only for legal accesses.
module sync_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]         i_wr_dat,
    input  logic                     i_rd_en,
    input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
    output logic [WIDTH-1:0]         o_rd_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rd_dat;

    // Storage is deliberately not reset; only the output register is.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, registered strobes, decoded level flags.
// Read data 1 cycle after rd_en; strobes 1 cycle after request; flags follow count.
// Writes when full are dropped (overflow), reads when empty are dropped (underflow).
// Optional SYNC_FIFO_SVA_EN compiles in embedded assertions and covers.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_WIDTH,
    parameter int FIFO_DEPTH = DEF_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef logic [AW-1:0] fifo_ptr_t;
    typedef logic [AW:0]   fifo_cnt_t;

    localparam fifo_cnt_t C_DEPTH   = fifo_cnt_t'(FIFO_DEPTH);
    localparam fifo_cnt_t C_AFULL   = fifo_cnt_t'(FIFO_DEPTH - 1);
    localparam fifo_cnt_t C_ONE     = fifo_cnt_t'(1);
    localparam fifo_ptr_t C_PTR_ONE = fifo_ptr_t'(1);

    fifo_ptr_t r_wr_ptr;
    fifo_ptr_t r_rd_ptr;
    fifo_cnt_t r_count;
    fifo_cnt_t w_count_nxt;
    logic      r_wr_ack;
    logic      r_overflow;
    logic      r_underflow;

    logic      w_full;
    logic      w_almostfull;
    logic      w_empty;
    logic      w_almostempty;
    logic      w_wr_ok;
    logic      w_rd_ok;
    op_t       w_op;
    logic [FIFO_WIDTH-1:0] w_rd_dat;

    assign w_full        = (r_count == C_DEPTH);
    assign w_almostfull  = (r_count == C_AFULL);
    assign w_empty       = (r_count == '0);
    assign w_almostempty = (r_count == C_ONE);

    // Acceptance uses the current count, so a read in the same cycle never frees room for a write.
    assign w_wr_ok = bus.wr_en & ~w_full;
    assign w_rd_ok = bus.rd_en & ~w_empty;
    assign w_op    = op_decode(w_wr_ok, w_rd_ok);

    always_comb begin
        w_count_nxt = r_count;
        case (w_op)
            OP_WR:   w_count_nxt = r_count + C_ONE;
            OP_RD:   w_count_nxt = r_count - C_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            r_count     <= w_count_nxt;
            r_wr_ack    <= w_wr_ok;
            r_overflow  <= bus.wr_en & w_full;
            r_underflow <= bus.rd_en & w_empty;
        end
    end

    sync_fifo_mem #(
        .WIDTH (FIFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_wr_ok & ~rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (bus.data_in),
        .i_rd_en   (w_rd_ok),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_dat)
    );

    assign bus.data_out    = w_rd_dat;
    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.almostfull  = w_almostfull;
    assign bus.empty       = w_empty;
    assign bus.almostempty = w_almostempty;

`ifdef SYNC_FIFO_SVA_EN
    localparam fifo_ptr_t C_PTR_MAX = fifo_ptr_t'(FIFO_DEPTH - 1);

    a_reset_state: assert property (@(posedge clk)
        rst |=> (!r_wr_ack && !r_overflow && !r_underflow &&
                 !w_full && !w_almostfull && !w_almostempty && w_empty))
        else $error("sync_fifo: outputs not cleared by reset");

    a_flag_count: assert property (@(posedge clk) disable iff (rst)
        (w_full == (r_count == C_DEPTH)) && (w_empty == (r_count == '0)) &&
        (w_almostfull == (r_count == C_AFULL)) && (w_almostempty == (r_count == C_ONE)) &&
        !(w_full && w_empty))
        else $error("sync_fifo: flags inconsistent with count");

    a_wr_ack: assert property (@(posedge clk) disable iff (rst)
        (bus.wr_en && !w_full) |=> r_wr_ack)
        else $error("sync_fifo: accepted write without wr_ack");

    a_overflow: assert property (@(posedge clk) disable iff (rst)
        (bus.wr_en && w_full) |=> (r_overflow && !r_wr_ack))
        else $error("sync_fifo: write when full without overflow");

    a_underflow: assert property (@(posedge clk) disable iff (rst)
        (bus.rd_en && w_empty) |=> r_underflow)
        else $error("sync_fifo: read when empty without underflow");

    a_wr_wrap: assert property (@(posedge clk) disable iff (rst)
        (w_wr_ok && r_wr_ptr == C_PTR_MAX) |=> (r_wr_ptr == '0))
        else $error("sync_fifo: write pointer failed to wrap");

    a_rd_wrap: assert property (@(posedge clk) disable iff (rst)
        (w_rd_ok && r_rd_ptr == C_PTR_MAX) |=> (r_rd_ptr == '0))
        else $error("sync_fifo: read pointer failed to wrap");

    a_count_range: assert property (@(posedge clk) disable iff (rst)
        r_count <= C_DEPTH)
        else $error("sync_fifo: count out of range");

    c_full:      cover property (@(posedge clk) disable iff (rst) w_full);
    c_overflow:  cover property (@(posedge clk) disable iff (rst) r_overflow);
    c_underflow: cover property (@(posedge clk) disable iff (rst) r_underflow);
    c_wr_wrap:   cover property (@(posedge clk) disable iff (rst) w_wr_ok && r_wr_ptr == C_PTR_MAX);
    c_both_full: cover property (@(posedge clk) disable iff (rst) bus.wr_en && bus.rd_en && w_full);
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized scoreboard bench for sync_fifo against a queue-based reference model.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int W = 16;
    localparam int D = 8;

    typedef struct {
        int          due;
        logic [15:0] dout;
        logic        ack;
        logic        ovf;
        logic        udf;
        logic        full;
        logic        afull;
        logic        empty;
        logic        aempty;
        int          cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t        exp_q[$];
    logic [15:0] model_q[$];
    logic [15:0] model_dout = '0;
    exp_t        mon_e;

    sync_fifo_if #(.FIFO_WIDTH(W)) bus ();

    sync_fifo #(.FIFO_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: compares every expectation when its cycle has been reached.
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            mon_e = exp_q.pop_front();
            check("data_out",    {16'h0, bus.data_out},  {16'h0, mon_e.dout});
            check("wr_ack",      {31'h0, bus.wr_ack},    {31'h0, mon_e.ack});
            check("overflow",    {31'h0, bus.overflow},  {31'h0, mon_e.ovf});
            check("underflow",   {31'h0, bus.underflow}, {31'h0, mon_e.udf});
            check("full",        {31'h0, bus.full},      {31'h0, mon_e.full});
            check("almostfull",  {31'h0, bus.almostfull},{31'h0, mon_e.afull});
            check("empty",       {31'h0, bus.empty},     {31'h0, mon_e.empty});
            check("almostempty", {31'h0, bus.almostempty},{31'h0, mon_e.aempty});
            check("count",       32'(dut.r_count),       32'(mon_e.cnt));
        end
    end

    // One clock of stimulus; the model decides the outcome from the queue occupancy.
    task automatic cycle(input bit r, input bit w, input bit rd, input logic [15:0] d);
        exp_t e;
        bit   was_full;
        bit   was_empty;
        rst         = r;
        bus.wr_en   = w;
        bus.rd_en   = rd;
        bus.data_in = d;
        e.due = cyc + 1;
        e.ack = 1'b0;
        e.ovf = 1'b0;
        e.udf = 1'b0;
        if (r) begin
            model_q.delete();
            model_dout = '0;
        end else begin
            was_full  = (model_q.size() == D);
            was_empty = (model_q.size() == 0);
            e.ack = w && !was_full;
            e.ovf = w && was_full;
            e.udf = rd && was_empty;
            if (rd && !was_empty) model_dout = model_q.pop_front();
            if (w && !was_full) model_q.push_back(d);
        end
        e.dout   = model_dout;
        e.cnt    = model_q.size();
        e.full   = (e.cnt == D);
        e.afull  = (e.cnt == D - 1);
        e.empty  = (e.cnt == 0);
        e.aempty = (e.cnt == 1);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int guard;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.data_in = '0;
        @(posedge clk);
        #1;

        // Reset for two cycles then idle
        cycle(1, 0, 0, 16'h0);
        cycle(1, 0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0);

        // Fill to full, then attempt an overflow write
        for (int i = 1; i <= D; i++) cycle(0, 1, 0, 16'(i));
        cycle(0, 1, 0, 16'hBEEF);
        cycle(0, 0, 0, 16'h0);

        // Drain completely plus one underflowing read
        for (int i = 0; i <= D; i++) cycle(0, 0, 1, 16'h0);
        cycle(0, 0, 0, 16'h0);

        // Simultaneous read/write at a steady level of four
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 16'($urandom));
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, 16'($urandom));

        // Reset with five entries held, then a single round trip
        cycle(0, 1, 0, 16'($urandom));
        cycle(1, 0, 0, 16'h0);
        cycle(0, 1, 0, 16'h1234);
        cycle(0, 0, 1, 16'h0);
        cycle(0, 0, 0, 16'h0);

        // Simultaneous access on full and on empty
        for (int i = 0; i < D; i++) cycle(0, 1, 0, 16'($urandom));
        cycle(0, 1, 1, 16'hDEAD);
        cycle(0, 1, 0, 16'($urandom));
        for (int i = 0; i < D; i++) cycle(0, 0, 1, 16'h0);
        cycle(0, 1, 1, 16'h5A5A);
        cycle(0, 0, 1, 16'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 55),
                  ($urandom_range(0, 99) < 50), 16'($urandom));

        cycle(0, 0, 0, 16'h0);
        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
